// File: rtl/spi_map_burst.sv
// SPI-driven register map: command byte selects address/direction, then a burst of
// data bytes writes registers or streams register values out, with optional auto-increment.
module spi_map_burst #(
   parameter int                  NREG    = 16,
   parameter logic [NREG-1:0]     RO_MASK = '0,
   parameter logic [8*NREG-1:0]   RST_VAL = '0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_spi_active,
   input  logic                i_rx_valid,
   input  logic [7:0]          vi_data_rx,
   input  logic                i_err_clr,
   input  logic [8*NREG-1:0]   vi_ro_data,
   output logic [8*NREG-1:0]   vo_rw_data,
   output logic [NREG-1:0]     vo_wr_strobe,
   output logic [NREG-1:0]     vo_rd_strobe,
   output logic [7:0]          vo_data_tx,
   output logic                o_err
);

   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

   typedef enum logic [2:0] {IDLE, CMD, WR, RD, DRAIN} state_e;

   state_e               state_q;
   logic [AW-1:0]        addr_q;
   logic                 inc_q;
   logic                 arm_q;
   logic [NREG-1:0][7:0] regs_q;

   logic [NREG-1:0][7:0] ro_v;
   logic [AW-1:0]        addr_d;
   logic [AW-1:0]        cmd_addr;
   logic                 rx;
   logic                 cmd_bad;
   logic                 err_ev;

   assign ro_v     = vi_ro_data;
   assign rx       = i_rx_valid & i_spi_active;
   assign cmd_bad  = {1'b0, vi_data_rx[5:0]} >= 7'(NREG);
   assign cmd_addr = vi_data_rx[AW-1:0];
   assign addr_d   = !inc_q ? addr_q :
                     (addr_q == AW'(NREG-1)) ? '0 : addr_q + AW'(1);
   assign err_ev   = rx && ((state_q == CMD && cmd_bad) ||
                            (state_q == WR && RO_MASK[addr_q]));

   function automatic logic [7:0] rd_val(input logic [AW-1:0] a);
      return RO_MASK[a] ? ro_v[a] : regs_q[a];
   endfunction

   for (genvar k = 0; k < NREG; k++) begin : g_out
      assign vo_rw_data[8*k +: 8] = RO_MASK[k] ? 8'h00 : regs_q[k];
   end

   // arm_q marks that chip-select was low last cycle, so a burst only starts on a
   // fresh rising edge (a reset mid-burst with chip-select still high stays idle).
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         inc_q        <= 1'b0;
         arm_q        <= 1'b0;
         regs_q       <= RST_VAL;
         vo_data_tx   <= 8'h00;
         vo_wr_strobe <= '0;
         vo_rd_strobe <= '0;
         o_err        <= 1'b0;
      end else begin
         vo_wr_strobe <= '0;
         vo_rd_strobe <= '0;
         arm_q        <= ~i_spi_active;
         o_err        <= err_ev | (o_err & ~i_err_clr);
         if (state_q != IDLE && !i_spi_active) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: if (i_spi_active && arm_q) state_q <= CMD;
               CMD: begin
                  if (rx) begin
                     if (cmd_bad) begin
                        state_q <= DRAIN;
                     end else begin
                        addr_q <= cmd_addr;
                        inc_q  <= vi_data_rx[6];
                        if (vi_data_rx[7]) begin
                           state_q <= WR;
                        end else begin
                           vo_data_tx             <= rd_val(cmd_addr);
                           vo_rd_strobe[cmd_addr] <= 1'b1;
                           state_q                <= RD;
                        end
                     end
                  end
               end
               WR: begin
                  if (rx) begin
                     if (!RO_MASK[addr_q]) begin
                        regs_q[addr_q]       <= vi_data_rx;
                        vo_wr_strobe[addr_q] <= 1'b1;
                     end
                     addr_q <= addr_d;
                  end
               end
               RD: begin
                  if (rx) begin
                     addr_q               <= addr_d;
                     vo_data_tx           <= rd_val(addr_d);
                     vo_rd_strobe[addr_d] <= 1'b1;
                  end
               end
               DRAIN: ;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_map_burst.sv
// Directed bench for spi_map_burst: 16 registers, reg1 read-only, reg14/15 non-zero reset.
module tb_spi_map_burst;

   localparam int            NREG = 16;
   localparam logic [15:0]   ROM  = 16'h0002;
   localparam logic [127:0]  RV   = {8'h5A, 8'hA5, 112'h0};

   logic          clk = 1'b0;
   logic          rst, act, rxv, eclr, err;
   logic [7:0]    drx, tx;
   logic [127:0]  ro_data, rw;
   logic [15:0]   wrs, rds;
   logic [15:0][7:0] exp_r;
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   spi_map_burst #(.NREG(NREG), .RO_MASK(ROM), .RST_VAL(RV)) dut (
      .i_clk(clk), .i_rst(rst), .i_spi_active(act), .i_rx_valid(rxv),
      .vi_data_rx(drx), .i_err_clr(eclr), .vi_ro_data(ro_data),
      .vo_rw_data(rw), .vo_wr_strobe(wrs), .vo_rd_strobe(rds),
      .vo_data_tx(tx), .o_err(err)
   );

   task automatic start_burst;
      @(negedge clk); act = 1'b1;
      @(negedge clk);
   endtask

   task automatic end_burst;
      @(negedge clk); act = 1'b0;
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk); rxv = 1'b1; drx = b;
      @(negedge clk); rxv = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      exp_r = RV;
      total++; if (rw !== exp_r) begin bad++; $display("FAIL reset_regs got=%h want=%h", rw, exp_r); end
      total++; if (wrs !== 16'h0 || rds !== 16'h0) begin bad++; $display("FAIL reset_strobes got=%h/%h want=0/0", wrs, rds); end
      total++; if (tx !== 8'h00) begin bad++; $display("FAIL reset_tx got=%h want=00", tx); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
   endtask

   task automatic test_write_inc;
      start_burst();
      send(8'hC3);
      total++; if (wrs !== 16'h0) begin bad++; $display("FAIL wr_cmd_strobe got=%h want=0000", wrs); end
      send(8'h11); exp_r[3] = 8'h11;
      total++; if (rw !== exp_r) begin bad++; $display("FAIL wr_b0_regs got=%h want=%h", rw, exp_r); end
      total++; if (wrs !== 16'h0008 || rds !== 16'h0) begin bad++; $display("FAIL wr_b0_strobe got=%h/%h want=0008/0000", wrs, rds); end
      send(8'h22); exp_r[4] = 8'h22;
      total++; if (wrs !== 16'h0010) begin bad++; $display("FAIL wr_b1_strobe got=%h want=0010", wrs); end
      send(8'h33); exp_r[5] = 8'h33;
      total++; if (wrs !== 16'h0020) begin bad++; $display("FAIL wr_b2_strobe got=%h want=0020", wrs); end
      total++; if (rw !== exp_r) begin bad++; $display("FAIL wr_final_regs got=%h want=%h", rw, exp_r); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", err); end
      end_burst();
      total++; if (wrs !== 16'h0) begin bad++; $display("FAIL wr_strobe_pulse got=%h want=0000", wrs); end
   endtask

   task automatic test_read_wrap;
      start_burst();
      send(8'h4E);
      total++; if (tx !== 8'hA5 || rds !== 16'h4000) begin bad++; $display("FAIL rd_r14 got=%h/%h want=a5/4000", tx, rds); end
      send(8'h00);
      total++; if (tx !== 8'h5A || rds !== 16'h8000) begin bad++; $display("FAIL rd_r15 got=%h/%h want=5a/8000", tx, rds); end
      send(8'hFF);
      total++; if (tx !== 8'h00 || rds !== 16'h0001) begin bad++; $display("FAIL rd_wrap got=%h/%h want=00/0001", tx, rds); end
      send(8'h00);
      total++; if (tx !== 8'h7E || rds !== 16'h0002 || wrs !== 16'h0) begin bad++; $display("FAIL rd_ro got=%h/%h/%h want=7e/0002/0000", tx, rds, wrs); end
      end_burst();
      total++; if (tx !== 8'h7E || rw !== exp_r) begin bad++; $display("FAIL rd_hold got=%h want=7e", tx); end
   endtask

   task automatic test_ro_write;
      start_burst();
      send(8'h81);
      send(8'hFF);
      total++; if (wrs !== 16'h0 || rw !== exp_r) begin bad++; $display("FAIL ro_nowrite got=%h/%h want=0000/%h", wrs, rw, exp_r); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL ro_err got=%b want=1", err); end
      end_burst();
      start_burst();
      send(8'h01);
      total++; if (tx !== 8'h7E || rds !== 16'h0002) begin bad++; $display("FAIL ro_readback got=%h/%h want=7e/0002", tx, rds); end
      end_burst();
      total++; if (err !== 1'b1) begin bad++; $display("FAIL ro_err_sticky got=%b want=1", err); end
      @(negedge clk); eclr = 1'b1;
      @(negedge clk); eclr = 1'b0;
      total++; if (err !== 1'b0) begin bad++; $display("FAIL ro_err_clr got=%b want=0", err); end
   endtask

   task automatic test_bad_addr;
      start_burst();
      @(negedge clk); rxv = 1'b1; drx = 8'h90; eclr = 1'b1;
      @(negedge clk); rxv = 1'b0; eclr = 1'b0;
      total++; if (err !== 1'b1 || rds !== 16'h0) begin bad++; $display("FAIL bad_err_wins got=%b/%h want=1/0000", err, rds); end
      send(8'h55);
      total++; if (rw !== exp_r || wrs !== 16'h0) begin bad++; $display("FAIL bad_drain got=%h/%h want=%h/0000", rw, wrs, exp_r); end
      send(8'h83);
      send(8'h66);
      total++; if (rw !== exp_r || wrs !== 16'h0) begin bad++; $display("FAIL bad_drain_cmd got=%h/%h want=%h/0000", rw, wrs, exp_r); end
      end_burst();
      @(negedge clk); eclr = 1'b1;
      @(negedge clk); eclr = 1'b0;
      total++; if (err !== 1'b0) begin bad++; $display("FAIL bad_err_clr got=%b want=0", err); end
   endtask

   task automatic test_no_inc;
      start_burst();
      send(8'h85);
      send(8'hAA); exp_r[5] = 8'hAA;
      total++; if (rw !== exp_r || wrs !== 16'h0020) begin bad++; $display("FAIL noinc_b0 got=%h/%h want=%h/0020", rw, wrs, exp_r); end
      send(8'hBB); exp_r[5] = 8'hBB;
      total++; if (rw !== exp_r || wrs !== 16'h0020) begin bad++; $display("FAIL noinc_b1 got=%h/%h want=%h/0020", rw, wrs, exp_r); end
      end_burst();
   endtask

   task automatic test_abort;
      start_burst();
      send(8'h82);
      send(8'h01); exp_r[2] = 8'h01;
      @(negedge clk); act = 1'b0; rxv = 1'b1; drx = 8'h02;
      @(negedge clk); rxv = 1'b0;
      total++; if (rw !== exp_r || wrs !== 16'h0) begin bad++; $display("FAIL abort_partial got=%h/%h want=%h/0000", rw, wrs, exp_r); end
      @(negedge clk); rxv = 1'b1; drx = 8'h03;
      @(negedge clk); rxv = 1'b0;
      total++; if (rw !== exp_r) begin bad++; $display("FAIL abort_idle_rx got=%h want=%h", rw, exp_r); end
      start_burst();
      send(8'h02);
      total++; if (tx !== 8'h01 || rds !== 16'h0004) begin bad++; $display("FAIL abort_restart got=%h/%h want=01/0004", tx, rds); end
      end_burst();
   endtask

   task automatic test_reset_mid;
      start_burst();
      send(8'hC7);
      send(8'h77); exp_r[7] = 8'h77;
      total++; if (rw !== exp_r || wrs !== 16'h0080) begin bad++; $display("FAIL mid_pre got=%h/%h want=%h/0080", rw, wrs, exp_r); end
      #2 rst = 1'b1;
      #1;
      exp_r = RV;
      total++; if (rw !== exp_r) begin bad++; $display("FAIL mid_async_regs got=%h want=%h", rw, exp_r); end
      total++; if (wrs !== 16'h0 || rds !== 16'h0 || tx !== 8'h00 || err !== 1'b0) begin bad++; $display("FAIL mid_async_out got=%h/%h/%h/%b want=0000/0000/00/0", wrs, rds, tx, err); end
      @(negedge clk); rst = 1'b0;
      send(8'hC3);
      send(8'h44);
      total++; if (rw !== exp_r || wrs !== 16'h0) begin bad++; $display("FAIL mid_no_rearm got=%h/%h want=%h/0000", rw, wrs, exp_r); end
      end_burst();
      start_burst();
      send(8'h0E);
      total++; if (tx !== 8'hA5 || rds !== 16'h4000) begin bad++; $display("FAIL mid_fresh_cmd got=%h/%h want=a5/4000", tx, rds); end
      end_burst();
   endtask

   initial begin
      rst = 1'b1; act = 1'b0; rxv = 1'b0; eclr = 1'b0; drx = 8'h00;
      ro_data = {{14{8'hEE}}, 8'h7E, 8'hEE};
      exp_r = RV;
      test_reset();
      test_write_inc();
      test_read_wrap();
      test_ro_write();
      test_bad_addr();
      test_no_inc();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_map_burst.md
SPI_MAP_BURST -- requirements
Module: spi_map_burst

Interface
REQ-001 The module SHALL have parameter NREG, default 16, meaning the number of 8-bit registers (legal range 1..64).
REQ-002 The module SHALL have parameter RO_MASK, width NREG, default all 0; bit k=1 makes register k read-only, and it reads vi_ro_data[8k+7:8k].
REQ-003 The module SHALL have parameter RST_VAL, width 8*NREG, default all 0, giving the reset value of each read/write register.
REQ-004 i_clk  input  1  sole clock; every input below is synchronous to it.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_spi_active  input  1  high while chip-select is asserted.
REQ-007 i_rx_valid  input  1  one-cycle pulse per received SPI byte.
REQ-008 vi_data_rx  input  8  received byte, valid when i_rx_valid=1.
REQ-009 i_err_clr  input  1  one-cycle pulse that clears o_err.
REQ-010 vi_ro_data  input  8*NREG  live values of read-only registers; slices of read/write registers are ignored.
REQ-011 vo_rw_data  output  8*NREG  register contents; read-only slices are driven 0.
REQ-012 vo_wr_strobe  output  NREG  bit k pulses one cycle when register k is written.
REQ-013 vo_rd_strobe  output  NREG  bit k pulses one cycle when register k is loaded for transmit.
REQ-014 vo_data_tx  output  8  byte to be shifted out on the next SPI byte.
REQ-015 o_err  output  1  sticky protocol-error flag.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, CMD, WR, RD, DRAIN.
REQ-017 IDLE SHALL go to CMD on the first cycle i_spi_active=1.
REQ-018 From every non-IDLE state, the FSM SHALL return to IDLE on the cycle after i_spi_active=0, regardless of any pending byte.
REQ-019 The command byte (first i_rx_valid in CMD) SHALL decode as bit7=W (1 write, 0 read), bit6=INC (auto-increment), bits[5:0]=ADDR.
REQ-020 If ADDR>=NREG, the FSM SHALL go to DRAIN and set o_err; DRAIN ignores all bytes until IDLE.
REQ-021 For a valid write command, the FSM SHALL latch ADDR and go to WR.
REQ-022 In WR, each i_rx_valid SHALL write vi_data_rx to register ADDR, visible on vo_rw_data one cycle after the pulse, with vo_wr_strobe[ADDR] high in that same cycle.
REQ-023 A WR byte targeting a read-only register SHALL leave the register unchanged, pulse no strobe, and set o_err; address advance still follows INC.
REQ-024 For a valid read command, the FSM SHALL load vo_data_tx with register ADDR one cycle after the command pulse, pulse vo_rd_strobe[ADDR] in that cycle, and go to RD.
REQ-025 In RD, each i_rx_valid (dummy byte, content ignored) SHALL advance the address per INC and reload vo_data_tx with the new register one cycle later, pulsing the matching rd strobe.
REQ-026 With INC=1, the address SHALL increment after each data byte and wrap from NREG-1 to 0.
REQ-027 With INC=0, the address SHALL stay fixed for the whole burst.
REQ-028 Writes SHALL be byte-atomic: a burst cut short by i_spi_active falling keeps all completed bytes and applies no partial byte.
REQ-029 i_rx_valid SHALL be ignored while i_spi_active=0 or in IDLE.
REQ-030 At most one bit of vo_wr_strobe and vo_rd_strobe combined SHALL be high in any cycle.
REQ-031 vo_data_tx SHALL hold its value between loads and SHALL NOT be cleared on IDLE.
REQ-032 o_err SHALL clear one cycle after i_err_clr; if an error event occurs in the same cycle as i_err_clr, the error wins and o_err stays 1.

Reset
REQ-033 While i_rst=1, the module SHALL hold state=IDLE, address=0, each read/write register=RST_VAL slice, vo_data_tx=0, all strobes=0 and o_err=0, asynchronously.
REQ-034 Deasserting i_rst SHALL take effect at the next i_clk edge; a reset mid-burst SHALL abort the burst, and the next command requires a fresh i_spi_active rising.

Verification
REQ-035 Bench: NREG=16; write cmd 0xC3, data 0x11,0x22,0x33 -> regs 3,4,5 = 0x11,0x22,0x33; vo_wr_strobe = 0x0008, 0x0010, 0x0020 on successive bytes; o_err=0.
REQ-036 Bench: RST_VAL reg14=0xA5, reg15=0x5A, reg0=0x00; read cmd 0x4E, then 3 dummy bytes -> vo_data_tx sequence 0xA5, 0x5A, 0x00 (wraps to 0).
REQ-037 Bench: RO_MASK=0x0002, vi_ro_data reg1=0x7E; write cmd 0x81, data 0xFF -> reg1 reads 0x7E, no wr strobe, o_err=1; then i_err_clr -> o_err=0.
REQ-038 Bench: cmd 0x90 (ADDR 16 >= NREG) followed by data 0x55 -> no register changes, o_err=1, FSM in DRAIN until i_spi_active=0.
REQ-039 Bench: write cmd 0x82, data 0x01, then i_spi_active drops before the 2nd byte's i_rx_valid -> reg2=0x01 only, FSM in IDLE the next cycle.
REQ-040 Bench: assert i_rst mid-write burst -> all outputs at reset values immediately, without waiting for an i_clk edge.
